// File: rtl/img_pkg.sv
// img_pkg: shared pixel widths, lane/receiver encodings and frame defaults.
`timescale 1ns/1ps
package img_pkg;
    localparam int PIXEL_W = 24;
    localparam int CHAN_W = 8;
    localparam int DEF_RAM_ADDR_BITS = 13;
    localparam int DEF_NUM_PIXELS = 8192;
    typedef enum logic [1:0] {LANE_R, LANE_G, LANE_B} lane_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/pixel_loader_if.sv
// pixel_loader_if: source pixel RAM write port.
`timescale 1ns/1ps
interface pixel_loader_if import img_pkg::*; #(parameter int ADDR_BITS = DEF_RAM_ADDR_BITS) ();
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [PIXEL_W-1:0]   wr_data;
    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pixel_loader_uart_rx_os.sv
// uart_rx_os: oversampling 8N1 receiver with rx synchronizer and tick generator.
`timescale 1ns/1ps
module uart_rx_os import img_pkg::*; #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  rx_byte,
    output logic        byte_valid,
    output logic        frame_err,
    output logic        tick
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] MID  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] LAST = OSW'(OVERSAMPLE - 1);

    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] div_q, div_d;
    logic          rx_s;
    rx_state_t     state_q;
    logic [OSW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          byte_valid_q, frame_err_q;

    always_comb begin
        rx_s   = sync_q[1];
        tick   = div_q == DW'(DIV - 1);
        sync_d = {sync_q[0], rx};
        div_d  = tick ? '0 : div_q + 1'b1;
    end

    // Synchronizer preloads to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sync_q <= 2'b11;
            div_q  <= '0;
        end else begin
            sync_q <= sync_d;
            div_q  <= div_d;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (tick)
                case (state_q)
                    RX_IDLE:
                        if (!rx_s) begin
                            state_q <= RX_START;
                            cnt_q   <= '0;
                        end
                    RX_START:
                        if (cnt_q == MID) begin
                            state_q <= rx_s ? RX_IDLE : RX_DATA;
                            cnt_q   <= '0;
                            bit_q   <= '0;
                        end else cnt_q <= cnt_q + 1'b1;
                    RX_DATA:
                        if (cnt_q == LAST) begin
                            shift_q <= {rx_s, shift_q[7:1]};
                            cnt_q   <= '0;
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == 3'd7) state_q <= RX_STOP;
                        end else cnt_q <= cnt_q + 1'b1;
                    RX_STOP:
                        if (cnt_q == LAST) begin
                            byte_valid_q <= rx_s;
                            frame_err_q  <= !rx_s;
                            state_q      <= RX_IDLE;
                            cnt_q        <= '0;
                        end else cnt_q <= cnt_q + 1'b1;
                    default: state_q <= RX_IDLE;
                endcase
        end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
endmodule

// File: rtl/pixel_loader.sv
// pixel_loader: packs UART RGB bytes into 24-bit pixels and writes them to source RAM.
`timescale 1ns/1ps
module pixel_loader import img_pkg::*; #(
    parameter int CLK_HZ        = 50000000,
    parameter int BAUD          = 115200,
    parameter int OVERSAMPLE    = 16,
    parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter int RAM_WIDTH     = PIXEL_W,
    parameter int NUM_PIXELS    = DEF_NUM_PIXELS,
    parameter int GAP_TICKS     = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             clear,
    pixel_loader_if.master   ram,
    output logic             busy,
    output logic             done,
    output logic             frame_err
);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
    localparam logic [RAM_ADDR_BITS-1:0] IDX_LAST = RAM_ADDR_BITS'(NUM_PIXELS - 1);

    logic [7:0] rx_byte;
    logic       byte_valid, tick;
    logic       take, wr, last, timeout;

    lane_t                    lane_q, lane_d;
    logic [CHAN_W-1:0]        r_q, r_d, g_q, g_d;
    logic [GW-1:0]            gap_q, gap_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d, wr_addr_q, wr_addr_d;
    logic [RAM_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                     wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;

    uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_rx (
        .clk(clk), .reset(reset), .rx(rx), .rx_byte(rx_byte),
        .byte_valid(byte_valid), .frame_err(frame_err), .tick(tick)
    );

    // clear outranks a byte arriving in the same cycle, so a frame restart never writes.
    always_comb begin
        take      = byte_valid && !done_q && !clear;
        wr        = take && lane_q == LANE_B;
        last      = idx_q == IDX_LAST;
        timeout   = lane_q != LANE_R && tick && !byte_valid && gap_q == GAP_LAST;
        r_d       = take && lane_q == LANE_R ? rx_byte : r_q;
        g_d       = take && lane_q == LANE_G ? rx_byte : g_q;
        wr_en_d   = wr;
        wr_addr_d = wr ? idx_q : wr_addr_q;
        wr_data_d = wr ? {r_q, g_q, rx_byte} : wr_data_q;
        idx_d     = clear ? '0 : wr ? (last ? '0 : idx_q + 1'b1) : idx_q;
        lane_d    = clear || timeout || wr ? LANE_R : take ? lane_t'(lane_q + 2'd1) : lane_q;
        gap_d     = clear || byte_valid || timeout ? '0 : lane_q != LANE_R && tick ? gap_q + 1'b1 : gap_q;
        done_d    = clear ? 1'b0 : wr && last ? 1'b1 : done_q;
        busy_d    = clear || (wr && last) ? 1'b0 : take ? 1'b1 : busy_q;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            lane_q    <= LANE_R;
            r_q       <= '0;
            g_q       <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            lane_q    <= lane_d;
            r_q       <= r_d;
            g_q       <= g_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end

    assign ram.wr_en   = wr_en_q;
    assign ram.wr_addr = wr_addr_q;
    assign ram.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_pixel_loader.sv
// tb_pixel_loader: directed UART stimulus with hand-computed pixel writes.
`timescale 1ns/1ps
module tb_pixel_loader;
    localparam int BIT = 32;

    logic clk = 1'b0, reset = 1'b0, rx = 1'b1, clear = 1'b0;
    logic busy, done, frame_err;
    int tests = 0, fails = 0;
    int wr_cnt = 0, fe_cnt = 0;
    logic [12:0] addr_log[$];
    logic [23:0] data_log[$];

    pixel_loader_if #(.ADDR_BITS(13)) bus ();

    pixel_loader #(
        .CLK_HZ(3686400), .BAUD(115200), .OVERSAMPLE(16), .RAM_ADDR_BITS(13),
        .RAM_WIDTH(24), .NUM_PIXELS(4), .GAP_TICKS(400)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .clear(clear), .ram(bus),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            wr_cnt++;
            addr_log.push_back(bus.wr_addr);
            data_log.push_back(bus.wr_data);
        end
        if (frame_err) fe_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_cnt = 0;
        fe_cnt = 0;
        addr_log.delete();
        data_log.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (24) @(negedge clk);
            rx = 1'b1;
            repeat (BIT * 3) @(negedge clk);
        end
    endtask

    task automatic send_pixel(input logic [23:0] p);
        send_byte(p[23:16], 1'b1);
        send_byte(p[15:8], 1'b1);
        send_byte(p[7:0], 1'b1);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_one_write(input string name, input logic [12:0] a, input logic [23:0] d);
        tests++;
        if (wr_cnt !== 1) begin
            fails++;
            $display("FAIL %s_count got %0d want 1", name, wr_cnt);
        end else begin
            tests++;
            if (addr_log[0] !== a || data_log[0] !== d) begin
                fails++;
                $display("FAIL %s_write got %h/%h want %h/%h", name, addr_log[0], data_log[0], a, d);
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        tests++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, frame_err} !== '0) begin
            fails++;
            $display("FAIL %s got en=%b addr=%h data=%h busy=%b done=%b ferr=%b want all 0",
                     name, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, frame_err);
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        check_zero_outputs("reset_outputs");
        reset = 1'b1;
        repeat (BIT * 2) @(negedge clk);
        check_zero_outputs("post_reset_idle");
    endtask

    task automatic test_single_pixel();
        clear_mon();
        send_pixel(24'h123456);
        check_one_write("single", 13'd0, 24'h123456);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL single_status got busy=%b done=%b want 1/0", busy, done);
        end
    endtask

    task automatic test_frame();
        logic [23:0] exp_data [4] = '{24'h000102, 24'h030405, 24'h060708, 24'h090A0B};
        pulse_clear();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL clear_busy got %b want 0", busy);
        end
        clear_mon();
        for (int i = 0; i < 12; i++) send_byte(8'(i), 1'b1);
        repeat (BIT) @(negedge clk);
        tests++;
        if (wr_cnt !== 4) begin
            fails++;
            $display("FAIL frame_count got %0d want 4", wr_cnt);
        end else
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (addr_log[i] !== 13'(i) || data_log[i] !== exp_data[i]) begin
                    fails++;
                    $display("FAIL frame_write%0d got %h/%h want %h/%h", i, addr_log[i], data_log[i], 13'(i), exp_data[i]);
                end
            end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL frame_done got done=%b busy=%b want 1/0", done, busy);
        end
        clear_mon();
        send_pixel(24'hC0FFEE);
        tests++;
        if (wr_cnt !== 0 || done !== 1'b1) begin
            fails++;
            $display("FAIL after_done got writes=%0d done=%b want 0/1", wr_cnt, done);
        end
    endtask

    task automatic test_clear();
        pulse_clear();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL clear_done got %b want 0", done);
        end
        clear_mon();
        send_pixel(24'h214365);
        check_one_write("clear", 13'd0, 24'h214365);
    endtask

    task automatic test_frame_err();
        pulse_clear();
        clear_mon();
        send_byte(8'hAA, 1'b0);
        tests++;
        if (fe_cnt !== 1 || wr_cnt !== 0) begin
            fails++;
            $display("FAIL ferr_pulse got ferr_cycles=%0d writes=%0d want 1/0", fe_cnt, wr_cnt);
        end
        send_pixel(24'h112233);
        check_one_write("ferr", 13'd0, 24'h112233);
        tests++;
        if (fe_cnt !== 1) begin
            fails++;
            $display("FAIL ferr_extra got %0d want 1", fe_cnt);
        end
    endtask

    task automatic test_gap();
        pulse_clear();
        clear_mon();
        send_byte(8'hFF, 1'b1);
        send_byte(8'hEE, 1'b1);
        repeat (1000) @(negedge clk);
        send_pixel(24'h010203);
        check_one_write("gap", 13'd0, 24'h010203);
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (BIT * 10) @(negedge clk);
        tests++;
        if (wr_cnt !== 0 || fe_cnt !== 0) begin
            fails++;
            $display("FAIL glitch got writes=%0d ferr=%0d want 0/0", wr_cnt, fe_cnt);
        end
        send_pixel(24'h445566);
        check_one_write("glitch", 13'd1, 24'h445566);
    endtask

    task automatic test_reset_mid();
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT * 3) @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("mid_reset_outputs");
        repeat (BIT) @(negedge clk);
        check_zero_outputs("mid_reset_hold");
        reset = 1'b1;
        repeat (BIT * 2) @(negedge clk);
        clear_mon();
        send_pixel(24'h9ABCDE);
        check_one_write("mid_reset", 13'd0, 24'h9ABCDE);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_status got busy=%b done=%b want 1/0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_frame();
        test_clear();
        test_frame_err();
        test_gap();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
